// File: rtl/pin_verifier_pkg.sv
// Shared types for the PIN verifier: FSM state encoding, BCD digit type and
// the width helper used for the digit counter.
package pin_verifier_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_GRANTED,
    ST_LOCKED
  } state_e;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pin_entry_buffer.sv
// Keypad entry shift register: each accepted digit shifts in at the LSB end so
// the first digit typed ends up in the MSBs once the entry is full.
module pin_entry_buffer
  import pin_verifier_pkg::*;
#(
  parameter int PIN_DIGITS = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                shift_i,
  input  logic                                clear_i,
  input  bcd_t                                digit_i,
  output logic [DIGIT_W*PIN_DIGITS-1:0]       entry_o,
  output logic [cnt_w(PIN_DIGITS)-1:0]        count_o
);

  localparam int EW = DIGIT_W * PIN_DIGITS;
  localparam int CW = cnt_w(PIN_DIGITS);

  logic [EW-1:0] entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (clear_i) begin
      entry_d = '0;
      count_d = '0;
    end else if (shift_i) begin
      entry_d = (entry_q << DIGIT_W) | EW'(digit_i);
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      count_q <= '0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign entry_o = entry_q;
  assign count_o = count_q;

endmodule

// File: rtl/pin_verifier.sv
// PIN collection and verification ahead of the ATM transaction FSM.
// Optional entry timeout is built in when PIN_TIMEOUT_EN is defined.
module pin_verifier
  import pin_verifier_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          card_in,
  input  logic                          digit_valid,
  input  bcd_t                          digit,
  input  logic                          clear_entry,
  input  logic                          enter,
  input  logic [DIGIT_W*PIN_DIGITS-1:0] stored_pin,
  output logic [cnt_w(PIN_DIGITS)-1:0]  digits_entered,
  output logic                          correct_password,
  output logic                          wrong_pin,
  output logic                          card_retained,
  output logic                          timeout
);

  localparam int EW = DIGIT_W * PIN_DIGITS;
  localparam int CW = cnt_w(PIN_DIGITS);
  localparam int AW = cnt_w(MAX_ATTEMPTS);

  state_e        state_q, state_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic          wrong_pin_q, wrong_pin_d;
  logic          fail;
  logic          buf_shift, buf_clear;
  logic          timeout_hit;
  logic [EW-1:0] entry;
  logic [CW-1:0] count;
  logic          entry_full;

  pin_entry_buffer #(
    .PIN_DIGITS(PIN_DIGITS)
  ) u_entry (
    .clk     (clk),
    .reset   (reset),
    .shift_i (buf_shift),
    .clear_i (buf_clear),
    .digit_i (digit),
    .entry_o (entry),
    .count_o (count)
  );

  assign entry_full = (count == CW'(PIN_DIGITS));

`ifdef PIN_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          timeout_q;
  logic          quiet_collect;

  // Any key activity, even one that is ignored, restarts the idle window.
  assign quiet_collect = card_in && (state_q == ST_COLLECT) &&
                         !(digit_valid || clear_entry || enter);
  assign timeout_hit   = quiet_collect && (idle_q == IW'(TIMEOUT_CYCLES - 1));
  assign idle_d        = (quiet_collect && !timeout_hit) ? idle_q + IW'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    attempts_d  = attempts_q;
    wrong_pin_d = 1'b0;
    fail        = 1'b0;
    buf_shift   = 1'b0;
    buf_clear   = 1'b0;

    if (!card_in) begin
      state_d    = ST_IDLE;
      attempts_d = '0;
      buf_clear  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_COLLECT;
        ST_COLLECT: begin
          if (clear_entry) begin
            buf_clear = 1'b1;
          end else if (enter) begin
            if (entry_full) state_d = ST_CHECK;
          end else if (digit_valid) begin
            buf_shift = (digit <= BCD_MAX) && !entry_full;
          end else if (timeout_hit) begin
            fail = 1'b1;
          end
        end
        ST_CHECK: begin
          if (entry == stored_pin) begin
            state_d = ST_GRANTED;
          end else begin
            wrong_pin_d = 1'b1;
            fail        = 1'b1;
          end
        end
        ST_GRANTED, ST_LOCKED: ;
        default:    state_d = ST_IDLE;
      endcase

      // A failed check and an entry timeout share the same penalty.
      if (fail) begin
        buf_clear  = 1'b1;
        attempts_d = attempts_q + AW'(1);
        state_d    = (attempts_d == AW'(MAX_ATTEMPTS)) ? ST_LOCKED : ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      attempts_q  <= '0;
      wrong_pin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      attempts_q  <= attempts_d;
      wrong_pin_q <= wrong_pin_d;
    end
  end

  assign digits_entered   = count;
  assign correct_password = (state_q == ST_GRANTED);
  assign card_retained    = (state_q == ST_LOCKED);
  assign wrong_pin        = wrong_pin_q;

endmodule

// File: tb/tb_pin_verifier.sv
// Self-checking bench for pin_verifier: expected output vectors are queued as
// each stimulus cycle is driven and compared one edge later.
module tb_pin_verifier;

  logic        clk;
  logic        reset;
  logic        card_in;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        clear_entry;
  logic        enter;
  logic [15:0] stored_pin;
  logic [2:0]  digits_entered;
  logic        correct_password;
  logic        wrong_pin;
  logic        card_retained;
  logic        timeout;

  logic [6:0]  obs;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pin_verifier #(
    .PIN_DIGITS     (4),
    .MAX_ATTEMPTS   (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .card_in          (card_in),
    .digit_valid      (digit_valid),
    .digit            (digit),
    .clear_entry      (clear_entry),
    .enter            (enter),
    .stored_pin       (stored_pin),
    .digits_entered   (digits_entered),
    .correct_password (correct_password),
    .wrong_pin        (wrong_pin),
    .card_retained    (card_retained),
    .timeout          (timeout)
  );

  // Observed vector layout: {digits_entered[2:0], correct_password, wrong_pin, card_retained, timeout}
  assign obs = {digits_entered, correct_password, wrong_pin, card_retained, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One stimulus cycle; the expectation applies just after the next rising edge.
  task automatic cyc(input string tag, input logic card, input logic dv, input logic [3:0] d,
                     input logic clr, input logic ent, input logic [2:0] cnt,
                     input logic cp, input logic wp, input logic cr, input logic to);
    exp_t e;
    @(negedge clk);
    card_in     = card;
    digit_valid = dv;
    digit       = d;
    clear_entry = clr;
    enter       = ent;
    e.tag = tag;
    e.exp = {cnt, cp, wp, cr, to};
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic key(input string tag, input logic [3:0] d, input logic [2:0] cnt);
    cyc(tag, 1'b1, 1'b1, d, 1'b0, 1'b0, cnt, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop(input string tag, input logic [2:0] cnt, input logic cp,
                     input logic wp, input logic cr);
    cyc(tag, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, cnt, cp, wp, cr, 1'b0);
  endtask

  task automatic press_enter(input string tag, input logic [2:0] cnt);
    cyc(tag, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, cnt, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pull(input string tag);
    cyc(tag, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic type_pin(input string tag, input logic [15:0] pin);
    logic [15:0] p;
    p = pin;
    for (int i = 0; i < 4; i++) begin
      key(tag, p[15:12], 3'(i + 1));
      p = p << 4;
    end
  endtask

  // Scoreboard consumer: compares the oldest queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, obs, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    card_in     = 1'b0;
    digit_valid = 1'b0;
    digit       = 4'd0;
    clear_entry = 1'b0;
    enter       = 1'b0;
    stored_pin  = 16'h1234;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", obs, 7'd0);
    @(negedge clk);
    reset = 1'b1;

    // Correct PIN: granted two edges after enter, held until card removed.
    pull("a_idle");
    nop("a_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    type_pin("a_key", 16'h1234);
    press_enter("a_enter", 3'd4);
    nop("a_granted", 3'd4, 1'b1, 1'b0, 1'b0);
    cyc("a_key_in_granted", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    nop("a_hold", 3'd4, 1'b1, 1'b0, 1'b0);
    pull("a_release");

    // Three wrong PINs: one wrong_pin pulse each, then lock.
    nop("b_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    for (int a = 1; a <= 3; a++) begin
      type_pin("b_key", 16'h1235);
      press_enter("b_enter", 3'd4);
      nop("b_wrong", 3'd0, 1'b0, 1'b1, (a == 3));
    end
    cyc("b_locked_key", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("b_locked_enter", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pull("b_release");

    // Short entry ignored; fifth digit dropped.
    nop("c_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    key("c_k1", 4'd1, 3'd1);
    key("c_k2", 4'd2, 3'd2);
    press_enter("c_short_enter", 3'd2);
    nop("c_no_check", 3'd2, 1'b0, 1'b0, 1'b0);
    key("c_k3", 4'd3, 3'd3);
    key("c_k4", 4'd4, 3'd4);
    key("c_k9_dropped", 4'd9, 3'd4);
    press_enter("c_enter", 3'd4);
    nop("c_granted", 3'd4, 1'b1, 1'b0, 1'b0);
    pull("c_release");

    // Non-BCD digits, clear priority, then async reset mid-entry.
    nop("d_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    key("d_kA", 4'hA, 3'd0);
    key("d_k7", 4'd7, 3'd1);
    key("d_kF", 4'hF, 3'd1);
    cyc("d_clear_and_digit", 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    key("d_k1", 4'd1, 3'd1);
    key("d_k2", 4'd2, 3'd2);
    key("d_k3", 4'd3, 3'd3);
    @(negedge clk);
    digit_valid = 1'b0;
    reset       = 1'b0;
    #1 check("d_reset_immediate", obs, 7'd0);
    @(posedge clk);
    #1 check("d_reset_hold", obs, 7'd0);
    @(negedge clk);
    card_in = 1'b0;
    reset   = 1'b1;

    // Card pulled during CHECK: no wrong_pin, entry cleared.
    pull("e_idle");
    nop("e_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    type_pin("e_key", 16'h1235);
    press_enter("e_enter", 3'd4);
    pull("e_pull_in_check");
    nop("e_recollect", 3'd0, 1'b0, 1'b0, 1'b0);
    nop("e_no_pulse", 3'd0, 1'b0, 1'b0, 1'b0);
    type_pin("e_key2", 16'h1234);
    press_enter("e_enter2", 3'd4);
    nop("e_granted", 3'd4, 1'b1, 1'b0, 1'b0);
    pull("e_release");

    // Entry timeout after eight quiet cycles (only when the feature is built).
    nop("f_collect", 3'd0, 1'b0, 1'b0, 1'b0);
    key("f_k1", 4'd1, 3'd1);
`ifdef PIN_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) nop("f_quiet", 3'd1, 1'b0, 1'b0, 1'b0);
      else cyc("f_timeout", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    nop("f_after_timeout", 3'd0, 1'b0, 1'b0, 1'b0);
    // Timeout consumed one attempt: two wrong PINs now lock the card.
    type_pin("f_key", 16'h1235);
    press_enter("f_enter", 3'd4);
    nop("f_wrong2", 3'd0, 1'b0, 1'b1, 1'b0);
    type_pin("f_key", 16'h1235);
    press_enter("f_enter", 3'd4);
    nop("f_wrong3_lock", 3'd0, 1'b0, 1'b1, 1'b1);
`else
    for (int i = 1; i <= 10; i++) begin
      nop("f_no_timeout", 3'd1, 1'b0, 1'b0, 1'b0);
    end
`endif
    pull("f_release");

    repeat (3) @(posedge clk);
    #2 check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
